// File: rtl/rv32_e_fdiv_sqrt_pkg.sv
// Shared FP32 types for the divide/sqrt unit, the FPU result path and the fflags/frm CSR logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32_e_fdiv_sqrt_pkg;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP32_PINF = 32'h7F80_0000;
    localparam logic [31:0] FP32_PMAX = 32'h7F7F_FFFF;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;
        logic        is_zero;
        logic        is_inf;
        logic        is_qnan;
        logic        is_snan;
        logic        is_sub;
    } fp_class_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_ITER,
        ST_ROUND,
        ST_DONE
    } ds_state_e;

endpackage

// File: rtl/rv32_e_fp_unpack.sv
// FP32 field split and operand classification (mant carries the hidden bit).
// Latency: combinational.
// Backpressure: none.
module rv32_e_fp_unpack
    import rv32_e_fdiv_sqrt_pkg::*;
(
    input  logic [31:0] val,
    output logic        sign,
    output logic [7:0]  exp,
    output logic [23:0] mant,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_qnan,
    output logic        is_snan,
    output logic        is_sub
);
    logic exp_min;
    logic exp_max;
    logic frac_nz;

    assign exp_min = (val[30:23] == 8'h00);
    assign exp_max = (val[30:23] == 8'hFF);
    assign frac_nz = |val[22:0];

    assign sign    = val[31];
    assign exp     = val[30:23];
    assign mant    = {~exp_min, val[22:0]};
    assign is_zero = exp_min & ~frac_nz;
    assign is_sub  = exp_min & frac_nz;
    assign is_inf  = exp_max & ~frac_nz;
    assign is_qnan = exp_max & val[22];
    assign is_snan = exp_max & ~val[22] & frac_nz;

endmodule

// File: rtl/rv32_e_fdiv_sqrt.sv
// Iterative FP32 divide / square root, radix-2 restoring; RV32_FDIVSQRT_RM_EN adds rm_i and all rounding modes.
// Latency: valid_o 29 cycles after start is accepted, 2 cycles for special operands.
// Backpressure: none; busy_o stalls issue and start_i is ignored while busy.
module rv32_e_fdiv_sqrt
    import rv32_e_fdiv_sqrt_pkg::*;
#(
    parameter int ITER_BITS = 26,
    parameter int CNT_W     = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic        kill_i,
`ifdef RV32_FDIVSQRT_RM_EN
    input  logic [2:0]  rm_i,
`endif
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic [4:0]  flags_o
);
    localparam int RW   = ITER_BITS + 4;
    localparam int RADW = 2 * ITER_BITS;

    ds_state_e          state, state_n;
    logic               op_r;
    logic [31:0]        a_r, b_r;
    rm_e                rm_r;
    logic [CNT_W-1:0]   cnt;
    logic [RW-1:0]      rem;
    logic [ITER_BITS-1:0] q;
    logic [RADW-1:0]    rad;
    logic [23:0]        mb_r;
    logic signed [9:0]  exp_r;
    logic               sign_r;
    logic [31:0]        result_r;
    fflags_t            flags_r;
    fp_class_t          ca, cb;

    rv32_e_fp_unpack u_unpack_a (
        .val(a_r), .sign(ca.sign), .exp(ca.exp), .mant(ca.mant), .is_zero(ca.is_zero),
        .is_inf(ca.is_inf), .is_qnan(ca.is_qnan), .is_snan(ca.is_snan), .is_sub(ca.is_sub)
    );
    rv32_e_fp_unpack u_unpack_b (
        .val(b_r), .sign(cb.sign), .exp(cb.exp), .mant(cb.mant), .is_zero(cb.is_zero),
        .is_inf(cb.is_inf), .is_qnan(cb.is_qnan), .is_snan(cb.is_snan), .is_sub(cb.is_sub)
    );

    // Subnormal operands are flushed: they classify as signed zero.
    logic a_zero, b_zero, a_nan, b_nan, sign_div;
    assign a_zero   = ca.is_zero | ca.is_sub;
    assign b_zero   = cb.is_zero | cb.is_sub;
    assign a_nan    = ca.is_qnan | ca.is_snan;
    assign b_nan    = cb.is_qnan | cb.is_snan;
    assign sign_div = ca.sign ^ cb.sign;

    logic signed [9:0] ea_s, eb_s, div_e, sqrt_e;
    logic [24:0]       xm;
    assign ea_s   = $signed({2'b00, ca.exp});
    assign eb_s   = $signed({2'b00, cb.exp});
    assign div_e  = ea_s - eb_s + 10'sd127;
    assign sqrt_e = ((ea_s - 10'sd127) >>> 1) + 10'sd127;
    // Odd unbiased exponent (even biased) doubles the radicand so the root stays in [1,2).
    assign xm     = ca.exp[0] ? {1'b0, ca.mant} : {ca.mant, 1'b0};

    logic        special;
    logic [31:0] spec_res;
    fflags_t     spec_flags;

    always_comb begin
        special    = 1'b1;
        spec_res   = FP32_QNAN;
        spec_flags = '0;
        if (rm_r > RM_RMM) begin
            spec_flags.nv = 1'b1;
        end else if (!op_r) begin
            if (a_nan | b_nan) begin
                spec_flags.nv = ca.is_snan | cb.is_snan;
            end else if ((a_zero & b_zero) | (ca.is_inf & cb.is_inf)) begin
                spec_flags.nv = 1'b1;
            end else if (ca.is_inf) begin
                spec_res = FP32_PINF | {sign_div, 31'd0};
            end else if (b_zero) begin
                spec_res      = FP32_PINF | {sign_div, 31'd0};
                spec_flags.dz = 1'b1;
            end else if (a_zero | cb.is_inf) begin
                spec_res = {sign_div, 31'd0};
            end else begin
                special = 1'b0;
            end
        end else begin
            if (a_nan) begin
                spec_flags.nv = ca.is_snan;
            end else if (a_zero) begin
                spec_res = {ca.sign, 31'd0};
            end else if (ca.sign) begin
                spec_flags.nv = 1'b1;
            end else if (ca.is_inf) begin
                spec_res = FP32_PINF;
            end else begin
                special = 1'b0;
            end
        end
    end

    // One recurrence step: divide compares/subtracts then shifts, sqrt brings in two radicand bits first.
    logic [RW-1:0] rem_sh, trial, rem_n;
    logic          q_bit;

    always_comb begin
        if (op_r) begin
            rem_sh = {rem[RW-3:0], rad[RADW-1 -: 2]};
            trial  = RW'({q, 2'b01});
        end else begin
            rem_sh = rem;
            trial  = RW'(mb_r);
        end
        q_bit = (rem_sh >= trial);
        rem_n = q_bit ? (rem_sh - trial) : rem_sh;
        if (!op_r) begin
            rem_n = rem_n << 1;
        end
    end

    logic                 lead, g, s, inc, sat;
    logic [ITER_BITS-1:0] qn;
    logic [23:0]          m;
    logic [24:0]          m_sum;
    logic signed [9:0]    e_n, e_f;
    logic [31:0]          rnd_res;
    fflags_t              rnd_flags;

    always_comb begin
        lead = q[ITER_BITS-1];
        qn   = lead ? q : (q << 1);
        m    = qn[ITER_BITS-1 -: 24];
        g    = qn[ITER_BITS-25];
        s    = (|qn[ITER_BITS-26:0]) | (|rem);
        case (rm_r)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign_r & (g | s);
            RM_RUP:  inc = ~sign_r & (g | s);
            RM_RMM:  inc = g;
            default: inc = g & (s | m[0]);
        endcase
        m_sum = {1'b0, m} + {24'd0, inc};
        e_n   = exp_r - (lead ? 10'sd0 : 10'sd1);
        e_f   = e_n + (m_sum[24] ? 10'sd1 : 10'sd0);
        sat   = (rm_r == RM_RTZ) | ((rm_r == RM_RDN) & ~sign_r) | ((rm_r == RM_RUP) & sign_r);
        rnd_flags    = '0;
        rnd_flags.nx = g | s;
        rnd_res      = {sign_r, e_f[7:0], (m_sum[24] ? 23'd0 : m_sum[22:0])};
        if (e_f >= 10'sd255) begin
            rnd_res      = (sat ? FP32_PMAX : FP32_PINF) | {sign_r, 31'd0};
            rnd_flags.of = 1'b1;
            rnd_flags.nx = 1'b1;
        end else if (e_f <= 10'sd0) begin
            rnd_res      = {sign_r, 31'd0};
            rnd_flags.uf = 1'b1;
            rnd_flags.nx = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (kill_i) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (start_i) state_n = ST_UNPACK;
                ST_UNPACK: state_n = special ? ST_DONE : ST_ITER;
                ST_ITER:   if (cnt == CNT_W'(ITER_BITS - 1)) state_n = ST_ROUND;
                ST_ROUND:  state_n = ST_DONE;
                default:   state_n = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o  = (state != ST_IDLE);
        valid_o = (state == ST_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_r     <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            cnt      <= '0;
            rem      <= '0;
            q        <= '0;
            rad      <= '0;
            mb_r     <= '0;
            exp_r    <= '0;
            sign_r   <= 1'b0;
            result_r <= '0;
            flags_r  <= '0;
        end else if (!kill_i) begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        op_r <= op_i;
                        a_r  <= src_a_i;
                        b_r  <= src_b_i;
                    end
                end
                ST_UNPACK: begin
                    cnt    <= '0;
                    q      <= '0;
                    mb_r   <= cb.mant;
                    sign_r <= op_r ? 1'b0 : sign_div;
                    rem    <= op_r ? '0 : RW'(ca.mant);
                    rad    <= {xm, {(RADW-25){1'b0}}};
                    exp_r  <= op_r ? sqrt_e : div_e;
                    if (special) begin
                        result_r <= spec_res;
                        flags_r  <= spec_flags;
                    end
                end
                ST_ITER: begin
                    cnt <= cnt + CNT_W'(1);
                    q   <= {q[ITER_BITS-2:0], q_bit};
                    rem <= rem_n;
                    rad <= rad << 2;
                end
                ST_ROUND: begin
                    result_r <= rnd_res;
                    flags_r  <= rnd_flags;
                end
                default: ;
            endcase
        end
    end

`ifdef RV32_FDIVSQRT_RM_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rm_r <= RM_RNE;
        end else if (!kill_i && state == ST_IDLE && start_i) begin
            rm_r <= rm_e'(rm_i);
        end
    end
`else
    assign rm_r = RM_RNE;
`endif

    assign result_o = result_r;
    assign flags_o  = flags_r;

endmodule
